rcpt_ptw: RTL and testbench
===========================

RCPT_PTW -- requirements
Module: rcpt_ptw

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 35, memory byte-address width; VPN_WIDTH, default 23, virtual page number width; PPN_WIDTH, default VPN_WIDTH, physical page number width; ATT_WIDTH, default 10, attribute width.
REQ-002 i_clk  in  1  sole clock, rising edge.
REQ-003 i_rst_n  in  1  asynchronous active-low reset.
REQ-004 i_req  in  1  TLB miss: walk request; accepted only while o_ready=1.
REQ-005 i_reqVPN  in  VPN_WIDTH  VPN that missed.
REQ-006 o_ready  out  1  walker idle, can accept i_req.
REQ-007 i_ptBase  in  ADDR_WIDTH  page-table base byte address, sampled at accept.
REQ-008 o_memReq / o_memAddr  out  1 / ADDR_WIDTH  read request and 8-byte-aligned entry address.
REQ-009 i_memGnt  in  1  request taken this cycle.
REQ-010 i_memRvalid / i_memRdata / i_memErr  in  1 / 64 / 1  read response, data and error flag.
REQ-011 o_ptwUpdate  out  1  one-cycle TLB-line fill strobe.
REQ-012 o_ptwVPN / o_ptwVPN_END  out  VPN_WIDTH  run start VPN and exclusive end VPN.
REQ-013 o_ptwPPN / o_ptwATT  out  PPN_WIDTH / ATT_WIDTH  PPN of run start and attributes.
REQ-014 o_walkFault  out  1  one-cycle strobe: walk failed, no fill.

Function
REQ-015 FSM states SHALL be IDLE, REQ, WAIT, UPD, with o_ready=1 only in IDLE.
REQ-016 IDLE with i_req=1 SHALL latch i_reqVPN and compute address = i_ptBase + (reqVPN << 3), truncated to ADDR_WIDTH (wrap, no carry out), and go to REQ.
REQ-017 In REQ, o_memReq SHALL be 1 and o_memAddr stable until the cycle i_memGnt=1, then go to WAIT.
REQ-018 In WAIT, i_memRvalid=1 SHALL capture the entry and go to UPD; i_memRvalid arriving in the same cycle as i_memGnt SHALL be accepted directly from REQ.
REQ-019 Entry format: [22:0] start VPN, [45:23] PPN, [55:46] ATT, [63:56] LEN; for non-default widths, fields are packed LSB-first in that order, zero-extended or truncated.
REQ-020 o_ptwVPN_END SHALL be start VPN + LEN + 1, modulo 2^VPN_WIDTH.
REQ-021 UPD SHALL last one cycle, then go to IDLE. In UPD, o_ptwUpdate=1 with the entry fields when start VPN <= reqVPN < VPN_END and i_memErr was 0.
REQ-022 Otherwise, including a range that wraps to VPN_END <= start, UPD SHALL assert o_walkFault=1 and o_ptwUpdate=0.
REQ-023 Attribute validity (all-ones ATT) SHALL NOT be checked here; ATT is passed through unchanged.
REQ-024 o_ptw* data outputs SHALL hold their last values outside UPD.
REQ-025 i_req outside IDLE SHALL be ignored, with no queueing.
REQ-026 Nominal latency, accept to update strobe, SHALL be 3 cycles with zero-wait grant and response.
REQ-027 i_memRvalid in IDLE or REQ, when not granted, SHALL be ignored.

Reset
REQ-028 Reset assertion SHALL immediately force IDLE, and all outputs SHALL be 0 except o_ready=1.
REQ-029 Reset mid-walk SHALL abandon the walk; a late response arriving after reset SHALL be ignored per REQ-027.

Configuration
REQ-030 Macro RCPT_PTW_LASTWALK_EN SHALL compile in a last-walk register, holding the start VPN, VPN_END, PPN, ATT and a valid bit of the last successful walk, cleared by reset.
REQ-031 With RCPT_PTW_LASTWALK_EN defined, an accepted reqVPN inside the stored valid range SHALL go IDLE->UPD with no memory access (1-cycle latency) and replay the stored fields.
REQ-032 Without RCPT_PTW_LASTWALK_EN defined, every request SHALL walk memory, and no extra state SHALL exist.

Verification
REQ-033 Basic walk: base=0x1000, reqVPN=0x10, entry {LEN=3, ATT=0x3FF, PPN=0x200, VPN=0x0E} -> o_memAddr=0x1080; update strobe with VPN=0x0E, VPN_END=0x12, PPN=0x200, 3 cycles after accept.
REQ-034 Grant stall: i_memGnt held low 4 cycles -> o_memReq and o_memAddr stable all 4 cycles, with one request issued.
REQ-035 Out-of-range entry: reqVPN=0x20 with entry VPN=0x0E, LEN=3 -> o_walkFault pulse, no o_ptwUpdate; same outcome for i_memErr=1.
REQ-036 Wrap: entry VPN=0x7FFFFF, LEN=0 -> VPN_END=0; o_walkFault.
REQ-037 Reset in WAIT, then response arrives -> no strobe; o_ready=1, next walk normal.
REQ-038 With RCPT_PTW_LASTWALK_EN, repeat of REQ-033 using reqVPN=0x11 -> no o_memReq; update one cycle after accept with identical fields.

Source files
------------

// File: rtl/rcpt_ptw.sv
// rcpt_ptw: single-level page-table walker that serves TLB misses.
//
// A miss (i_req with i_reqVPN) is accepted only while idle. The entry address
// i_ptBase + (vpn << 3) is issued as one 8-byte read. The returned 64-bit entry
// describes a run of pages [start, start+LEN+1). If the missing VPN falls in
// that run and the read had no error, a one-cycle TLB fill strobe is raised.
// Otherwise a one-cycle walk-fault strobe is raised instead.
//
// Ports
//   i_clk, i_rst_n                 clock, async active-low reset
//   i_req, i_reqVPN, o_ready       miss request handshake
//   i_ptBase                       page-table base, sampled at accept
//   o_memReq, o_memAddr, i_memGnt  entry read request
//   i_memRvalid, i_memRdata,
//   i_memErr                       entry read response
//   o_ptwUpdate, o_ptwVPN, o_ptwVPN_END,
//   o_ptwPPN, o_ptwATT             TLB fill strobe and fields
//   o_walkFault                    walk-fault strobe
//
// Optional feature: define RCPT_PTW_LASTWALK_EN to keep the last successful
// walk and replay it, without a memory access, for requests inside its range.
//
// state  | meaning
// S_IDLE | ready for a miss
// S_REQ  | entry read requested, waiting for grant
// S_WAIT | read granted, waiting for response
// S_UPD  | one cycle of fill or fault strobe

module rcpt_ptw #(
   parameter int ADDR_WIDTH = 35,
   parameter int VPN_WIDTH  = 23,
   parameter int PPN_WIDTH  = VPN_WIDTH,
   parameter int ATT_WIDTH  = 10
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_req,
   input  logic [VPN_WIDTH-1:0]  i_reqVPN,
   output logic                  o_ready,
   input  logic [ADDR_WIDTH-1:0] i_ptBase,
   output logic                  o_memReq,
   output logic [ADDR_WIDTH-1:0] o_memAddr,
   input  logic                  i_memGnt,
   input  logic                  i_memRvalid,
   input  logic [63:0]           i_memRdata,
   input  logic                  i_memErr,
   output logic                  o_ptwUpdate,
   output logic [VPN_WIDTH-1:0]  o_ptwVPN,
   output logic [VPN_WIDTH-1:0]  o_ptwVPN_END,
   output logic [PPN_WIDTH-1:0]  o_ptwPPN,
   output logic [ATT_WIDTH-1:0]  o_ptwATT,
   output logic                  o_walkFault
);

   localparam int ENT_W = VPN_WIDTH + PPN_WIDTH + ATT_WIDTH + 8;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_UPD} state_t;

   state_t                 state;
   logic [VPN_WIDTH-1:0]   req_vpn;

   // Fields are packed LSB-first; the cast zero-extends or truncates the
   // 64-bit entry to exactly the packed field width.
   logic [ENT_W-1:0]       ent;
   logic [VPN_WIDTH-1:0]   e_vpn;
   logic [PPN_WIDTH-1:0]   e_ppn;
   logic [ATT_WIDTH-1:0]   e_att;
   logic [7:0]             e_len;
   logic [VPN_WIDTH-1:0]   e_end;
   logic                   e_hit;
   logic                   resp_take;
   logic [ADDR_WIDTH-1:0]  walk_addr;

   assign ent   = ENT_W'(i_memRdata);
   assign e_vpn = ent[VPN_WIDTH-1:0];
   assign e_ppn = ent[VPN_WIDTH +: PPN_WIDTH];
   assign e_att = ent[VPN_WIDTH+PPN_WIDTH +: ATT_WIDTH];
   assign e_len = ent[ENT_W-1 -: 8];

   // Exclusive end wraps modulo 2^VPN_WIDTH; a wrapped run fails the range
   // test below on its own, so it needs no separate check.
   assign e_end = e_vpn + VPN_WIDTH'(e_len) + VPN_WIDTH'(1);
   assign e_hit = (e_vpn <= req_vpn) && (req_vpn < e_end) && !i_memErr;

   // A response is only meaningful once the read has been granted; it may
   // coincide with the grant itself.
   assign resp_take = i_memRvalid &&
                      (((state == S_REQ) && i_memGnt) || (state == S_WAIT));

   assign walk_addr = i_ptBase + ADDR_WIDTH'({i_reqVPN, 3'b000});

`ifdef RCPT_PTW_LASTWALK_EN
   logic                  lw_valid;
   logic [VPN_WIDTH-1:0]  lw_vpn;
   logic [VPN_WIDTH-1:0]  lw_end;
   logic [PPN_WIDTH-1:0]  lw_ppn;
   logic [ATT_WIDTH-1:0]  lw_att;
   logic                  lw_hit;

   assign lw_hit = lw_valid && (lw_vpn <= i_reqVPN) && (i_reqVPN < lw_end);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         lw_valid <= 1'b0;
         lw_vpn   <= '0;
         lw_end   <= '0;
         lw_ppn   <= '0;
         lw_att   <= '0;
      end else if (resp_take && e_hit) begin
         lw_valid <= 1'b1;
         lw_vpn   <= e_vpn;
         lw_end   <= e_end;
         lw_ppn   <= e_ppn;
         lw_att   <= e_att;
      end
   end
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state        <= S_IDLE;
         req_vpn      <= '0;
         o_ready      <= 1'b1;
         o_memReq     <= 1'b0;
         o_memAddr    <= '0;
         o_ptwUpdate  <= 1'b0;
         o_ptwVPN     <= '0;
         o_ptwVPN_END <= '0;
         o_ptwPPN     <= '0;
         o_ptwATT     <= '0;
         o_walkFault  <= 1'b0;
      end else begin
         o_ptwUpdate <= 1'b0;
         o_walkFault <= 1'b0;
         case (state)
            S_IDLE: begin
               if (i_req) begin
                  req_vpn   <= i_reqVPN;
                  o_ready   <= 1'b0;
                  state     <= S_REQ;
                  o_memReq  <= 1'b1;
                  o_memAddr <= walk_addr;
`ifdef RCPT_PTW_LASTWALK_EN
                  if (lw_hit) begin
                     state        <= S_UPD;
                     o_memReq     <= 1'b0;
                     o_memAddr    <= o_memAddr;
                     o_ptwUpdate  <= 1'b1;
                     o_ptwVPN     <= lw_vpn;
                     o_ptwVPN_END <= lw_end;
                     o_ptwPPN     <= lw_ppn;
                     o_ptwATT     <= lw_att;
                  end
`endif
               end
            end
            S_REQ: begin
               if (i_memGnt) begin
                  o_memReq <= 1'b0;
                  state    <= S_WAIT;
               end
            end
            S_WAIT: ;
            S_UPD: begin
               state   <= S_IDLE;
               o_ready <= 1'b1;
            end
            default: state <= S_IDLE;
         endcase

         if (resp_take) begin
            state    <= S_UPD;
            o_memReq <= 1'b0;
            if (e_hit) begin
               o_ptwUpdate  <= 1'b1;
               o_ptwVPN     <= e_vpn;
               o_ptwVPN_END <= e_end;
               o_ptwPPN     <= e_ppn;
               o_ptwATT     <= e_att;
            end else begin
               o_walkFault <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_rcpt_ptw.sv
module tb_rcpt_ptw;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_req = 1'b0;
   logic [22:0] i_reqVPN = '0;
   logic        o_ready;
   logic [34:0] i_ptBase = '0;
   logic        o_memReq;
   logic [34:0] o_memAddr;
   logic        i_memGnt = 1'b0;
   logic        i_memRvalid = 1'b0;
   logic [63:0] i_memRdata = '0;
   logic        i_memErr = 1'b0;
   logic        o_ptwUpdate;
   logic [22:0] o_ptwVPN;
   logic [22:0] o_ptwVPN_END;
   logic [22:0] o_ptwPPN;
   logic [9:0]  o_ptwATT;
   logic        o_walkFault;

   int total = 0;
   int bad = 0;

   rcpt_ptw dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_reqVPN(i_reqVPN),
      .o_ready(o_ready), .i_ptBase(i_ptBase), .o_memReq(o_memReq),
      .o_memAddr(o_memAddr), .i_memGnt(i_memGnt), .i_memRvalid(i_memRvalid),
      .i_memRdata(i_memRdata), .i_memErr(i_memErr), .o_ptwUpdate(o_ptwUpdate),
      .o_ptwVPN(o_ptwVPN), .o_ptwVPN_END(o_ptwVPN_END), .o_ptwPPN(o_ptwPPN),
      .o_ptwATT(o_ptwATT), .o_walkFault(o_walkFault)
   );

   always #5 i_clk = ~i_clk;

   function automatic logic [63:0] mk_entry(input logic [7:0] len, input logic [9:0] att,
                                            input logic [22:0] ppn, input logic [22:0] vpn);
      return {len, att, ppn, vpn};
   endfunction

   // advance one rising edge, return at the following falling edge
   task automatic tick();
      @(posedge i_clk);
      @(negedge i_clk);
   endtask

   task automatic issue(input logic [22:0] vpn, input logic [34:0] base);
      i_req = 1'b1;
      i_reqVPN = vpn;
      i_ptBase = base;
      tick();
      i_req = 1'b0;
   endtask

   task automatic test_reset();
      i_rst_n = 1'b0;
      tick();
      total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got %b want 1", o_ready); end
      total++; if (o_memReq !== 1'b0) begin bad++; $display("FAIL reset_memReq got %b want 0", o_memReq); end
      total++; if ({o_ptwUpdate, o_walkFault} !== 2'b00) begin bad++; $display("FAIL reset_strobes got %b want 00", {o_ptwUpdate, o_walkFault}); end
      total++; if (o_memAddr !== 35'h0 || o_ptwVPN !== 23'h0 || o_ptwVPN_END !== 23'h0 || o_ptwPPN !== 23'h0 || o_ptwATT !== 10'h0) begin
         bad++; $display("FAIL reset_data got addr=%h vpn=%h end=%h ppn=%h att=%h want all 0", o_memAddr, o_ptwVPN, o_ptwVPN_END, o_ptwPPN, o_ptwATT);
      end
      i_rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic_walk();
      issue(23'h10, 35'h1000);
      total++; if (o_memReq !== 1'b1 || o_ready !== 1'b0) begin bad++; $display("FAIL basic_req got memReq=%b ready=%b want 1 0", o_memReq, o_ready); end
      total++; if (o_memAddr !== 35'h1080) begin bad++; $display("FAIL basic_addr got %h want 1080", o_memAddr); end
      i_memGnt = 1'b1;
      tick();
      i_memGnt = 1'b0;
      total++; if (o_memReq !== 1'b0 || o_ptwUpdate !== 1'b0) begin bad++; $display("FAIL basic_wait got memReq=%b upd=%b want 0 0", o_memReq, o_ptwUpdate); end
      i_memRvalid = 1'b1;
      i_memRdata = mk_entry(8'd3, 10'h3FF, 23'h200, 23'h0E);
      tick();
      i_memRvalid = 1'b0;
      total++; if (o_ptwUpdate !== 1'b1 || o_walkFault !== 1'b0) begin bad++; $display("FAIL basic_strobe got upd=%b flt=%b want 1 0", o_ptwUpdate, o_walkFault); end
      total++; if (o_ptwVPN !== 23'h0E || o_ptwVPN_END !== 23'h12 || o_ptwPPN !== 23'h200 || o_ptwATT !== 10'h3FF) begin
         bad++; $display("FAIL basic_fields got vpn=%h end=%h ppn=%h att=%h want 0e 12 200 3ff", o_ptwVPN, o_ptwVPN_END, o_ptwPPN, o_ptwATT);
      end
      tick();
      total++; if (o_ptwUpdate !== 1'b0 || o_ready !== 1'b1) begin bad++; $display("FAIL basic_done got upd=%b ready=%b want 0 1", o_ptwUpdate, o_ready); end
      total++; if (o_ptwVPN !== 23'h0E || o_ptwPPN !== 23'h200) begin bad++; $display("FAIL basic_hold got vpn=%h ppn=%h want 0e 200", o_ptwVPN, o_ptwPPN); end
   endtask

`ifdef RCPT_PTW_LASTWALK_EN
   task automatic test_lastwalk();
      issue(23'h11, 35'h1000);
      total++; if (o_memReq !== 1'b0) begin bad++; $display("FAIL lw_memReq got %b want 0", o_memReq); end
      total++; if (o_ptwUpdate !== 1'b1 || o_walkFault !== 1'b0) begin bad++; $display("FAIL lw_strobe got upd=%b flt=%b want 1 0", o_ptwUpdate, o_walkFault); end
      total++; if (o_ptwVPN !== 23'h0E || o_ptwVPN_END !== 23'h12 || o_ptwPPN !== 23'h200 || o_ptwATT !== 10'h3FF) begin
         bad++; $display("FAIL lw_fields got vpn=%h end=%h ppn=%h att=%h want 0e 12 200 3ff", o_ptwVPN, o_ptwVPN_END, o_ptwPPN, o_ptwATT);
      end
      tick();
      total++; if (o_ready !== 1'b1 || o_memReq !== 1'b0) begin bad++; $display("FAIL lw_done got ready=%b memReq=%b want 1 0", o_ready, o_memReq); end
   endtask
`endif

   task automatic test_grant_stall();
      int req_cycles;
      issue(23'h40, 35'h1000);
      req_cycles = 0;
      // busy-time request and ungranted response must both be ignored
      i_req = 1'b1;
      i_reqVPN = 23'h55;
      i_memRvalid = 1'b1;
      i_memRdata = mk_entry(8'd0, 10'h1, 23'h1, 23'h7000);
      for (int c = 0; c < 4; c++) begin
         total++; if (o_memReq !== 1'b1 || o_memAddr !== 35'h1200) begin
            bad++; $display("FAIL stall_hold cyc=%0d got memReq=%b addr=%h want 1 1200", c, o_memReq, o_memAddr);
         end
         if (o_memReq === 1'b1) req_cycles++;
         tick();
      end
      i_req = 1'b0;
      total++; if (o_ptwUpdate !== 1'b0 || o_walkFault !== 1'b0) begin bad++; $display("FAIL stall_nostrobe got upd=%b flt=%b want 0 0", o_ptwUpdate, o_walkFault); end
      // grant and response in the same cycle
      i_memGnt = 1'b1;
      i_memRdata = mk_entry(8'd0, 10'h15, 23'h333, 23'h40);
      tick();
      i_memGnt = 1'b0;
      i_memRvalid = 1'b0;
      total++; if (o_memReq !== 1'b0) begin bad++; $display("FAIL stall_single got memReq=%b want 0", o_memReq); end
      total++; if (o_ptwUpdate !== 1'b1 || o_ptwVPN !== 23'h40 || o_ptwVPN_END !== 23'h41 || o_ptwPPN !== 23'h333 || o_ptwATT !== 10'h15) begin
         bad++; $display("FAIL stall_fill got upd=%b vpn=%h end=%h ppn=%h att=%h want 1 40 41 333 015", o_ptwUpdate, o_ptwVPN, o_ptwVPN_END, o_ptwPPN, o_ptwATT);
      end
      total++; if (req_cycles != 4) begin bad++; $display("FAIL stall_count got %0d want 4", req_cycles); end
      tick();
      total++; if (o_ready !== 1'b1 || o_memReq !== 1'b0) begin bad++; $display("FAIL stall_noqueue got ready=%b memReq=%b want 1 0", o_ready, o_memReq); end
   endtask

   task automatic test_out_of_range();
      issue(23'h20, 35'h1000);
      i_memGnt = 1'b1;
      tick();
      i_memGnt = 1'b0;
      i_memRvalid = 1'b1;
      i_memRdata = mk_entry(8'd3, 10'h3FF, 23'h200, 23'h0E);
      tick();
      i_memRvalid = 1'b0;
      total++; if (o_walkFault !== 1'b1 || o_ptwUpdate !== 1'b0) begin bad++; $display("FAIL oor_strobe got flt=%b upd=%b want 1 0", o_walkFault, o_ptwUpdate); end
      total++; if (o_ptwVPN !== 23'h40 || o_ptwPPN !== 23'h333) begin bad++; $display("FAIL oor_hold got vpn=%h ppn=%h want 40 333", o_ptwVPN, o_ptwPPN); end
      tick();
      total++; if (o_walkFault !== 1'b0 || o_ready !== 1'b1) begin bad++; $display("FAIL oor_done got flt=%b ready=%b want 0 1", o_walkFault, o_ready); end
      // in-range entry but read error
      issue(23'h50, 35'h1000);
      i_memGnt = 1'b1;
      tick();
      i_memGnt = 1'b0;
      i_memRvalid = 1'b1;
      i_memErr = 1'b1;
      i_memRdata = mk_entry(8'd0, 10'h2, 23'h2, 23'h50);
      tick();
      i_memRvalid = 1'b0;
      i_memErr = 1'b0;
      total++; if (o_walkFault !== 1'b1 || o_ptwUpdate !== 1'b0) begin bad++; $display("FAIL err_strobe got flt=%b upd=%b want 1 0", o_walkFault, o_ptwUpdate); end
      tick();
   endtask

   task automatic test_wrap();
      // base near the top of the address space: entry address wraps
      issue(23'h7FFFFF, 35'h7_FFFF_FFF8);
      total++; if (o_memAddr !== 35'h0_03FF_FFF0) begin bad++; $display("FAIL wrap_addr got %h want 003fffff0", o_memAddr); end
      i_memGnt = 1'b1;
      tick();
      i_memGnt = 1'b0;
      i_memRvalid = 1'b1;
      i_memRdata = mk_entry(8'd0, 10'h3FF, 23'h1, 23'h7FFFFF);
      tick();
      i_memRvalid = 1'b0;
      total++; if (o_walkFault !== 1'b1 || o_ptwUpdate !== 1'b0) begin bad++; $display("FAIL wrap_strobe got flt=%b upd=%b want 1 0", o_walkFault, o_ptwUpdate); end
      tick();
   endtask

   task automatic test_reset_mid_walk();
      issue(23'h60, 35'h1000);
      i_memGnt = 1'b1;
      tick();
      i_memGnt = 1'b0;
      #2 i_rst_n = 1'b0;
      #1;
      total++; if (o_ready !== 1'b1 || o_memReq !== 1'b0) begin bad++; $display("FAIL midrst_async got ready=%b memReq=%b want 1 0", o_ready, o_memReq); end
      @(negedge i_clk);
      i_rst_n = 1'b1;
      i_memRvalid = 1'b1;
      i_memRdata = mk_entry(8'd0, 10'h1, 23'h1, 23'h60);
      tick();
      i_memRvalid = 1'b0;
      tick();
      total++; if (o_ptwUpdate !== 1'b0 || o_walkFault !== 1'b0 || o_ready !== 1'b1) begin
         bad++; $display("FAIL midrst_late got upd=%b flt=%b ready=%b want 0 0 1", o_ptwUpdate, o_walkFault, o_ready);
      end
      test_basic_walk();
   endtask

   initial begin
      test_reset();
      test_basic_walk();
`ifdef RCPT_PTW_LASTWALK_EN
      test_lastwalk();
`endif
      test_grant_stall();
      test_out_of_range();
      test_wrap();
      test_reset_mid_walk();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
